// File: rtl/fp_pack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pack
//  Description : Output stage of the FPU datapath. Normalises an unpacked
//                result (biased exponent, significand with explicit hidden
//                bit, sign, special flags), resolves NaN/inf/zero, overflow
//                and underflow, and packs an IEEE-754 word. Two-stage
//                valid/ready pipeline, one result per cycle.
//                Optional build macro FP_PACK_SUBNORMAL_EN: produce
//                subnormals instead of flushing underflows to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_pack #(
    parameter int FW = 23,
    parameter int EW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EW-1:0]    exponent,
    input  logic [FW:0]      significant,
    input  logic             sign,
    input  logic             inf,
    input  logic             nan,
    input  logic             zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+FW:0]   result,
    output logic             flag_nv,
    output logic             flag_of,
    output logic             flag_uf
);

    localparam int LZW = $clog2(FW + 2);

    // Leading-zero count of the significand; FW+1 when it is all zeros.
    function automatic logic [LZW-1:0] count_lz(input logic [FW:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = LZW'(FW + 1);
        found = 1'b0;
        for (int i = FW; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = LZW'(FW - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [EW-1:0]    s1_exp_q,   s1_exp_d;
    logic [FW:0]      s1_sig_q,   s1_sig_d;
    logic             s1_sign_q,  s1_sign_d;
    logic             s1_inf_q,   s1_inf_d;
    logic             s1_nan_q,   s1_nan_d;
    logic             s1_zero_q,  s1_zero_d;
    logic [LZW-1:0]   s1_lz_q,    s1_lz_d;

    // Stage 2 state
    logic             s2_valid_q, s2_valid_d;
    logic [EW+FW:0]   res_q,      res_d;
    logic             nv_q,       nv_d;
    logic             of_q,       of_d;
    logic             uf_q,       uf_d;

    logic             s2_adv;
    logic [EW:0]      exp_ext;
    logic [EW:0]      lz_ext;
    logic [EW:0]      exp_diff;
    logic [FW-1:0]    norm_frac;
`ifdef FP_PACK_SUBNORMAL_EN
    logic [EW-1:0]    sub_shift;
    logic [FW-1:0]    sub_frac;
`endif

    assign s2_adv    = ~s2_valid_q | out_ready;
    assign in_ready  = ~s1_valid_q | s2_adv;
    assign out_valid = s2_valid_q;
    assign result    = res_q;
    assign flag_nv   = nv_q;
    assign flag_of   = of_q;
    assign flag_uf   = uf_q;

    // Stage 1 next state: capture the bundle and its leading-zero count on accept.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_exp_d   = s1_exp_q;
        s1_sig_d   = s1_sig_q;
        s1_sign_d  = s1_sign_q;
        s1_inf_d   = s1_inf_q;
        s1_nan_d   = s1_nan_q;
        s1_zero_d  = s1_zero_q;
        s1_lz_d    = s1_lz_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_exp_d  = exponent;
                s1_sig_d  = significant;
                s1_sign_d = sign;
                s1_inf_d  = inf;
                s1_nan_d  = nan;
                s1_zero_d = zero;
                s1_lz_d   = count_lz(significant);
            end
        end
    end

    // Exponent arithmetic is one bit wider than the field so it cannot wrap.
    assign exp_ext   = {1'b0, s1_exp_q};
    assign lz_ext    = (EW+1)'(s1_lz_q);
    assign exp_diff  = exp_ext - lz_ext;
    assign norm_frac = FW'(s1_sig_q << s1_lz_q);
`ifdef FP_PACK_SUBNORMAL_EN
    // Subnormal scale uses max(exponent,1)-1, so exponent 0 shifts by zero.
    assign sub_shift = (s1_exp_q == '0) ? '0 : s1_exp_q - EW'(1);
    assign sub_frac  = FW'(s1_sig_q << sub_shift);
`endif

    // Stage 2 next state: classify and pack in priority order when stage 2 advances.
    always_comb begin
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        nv_d       = nv_q;
        of_d       = of_q;
        uf_d       = uf_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                nv_d = 1'b0;
                of_d = 1'b0;
                uf_d = 1'b0;
                if (s1_nan_q) begin
                    res_d = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
                    nv_d  = 1'b1;
                end else if (s1_inf_q) begin
                    res_d = {s1_sign_q, {EW{1'b1}}, {FW{1'b0}}};
                end else if (s1_zero_q || (s1_sig_q == '0)) begin
                    res_d = {s1_sign_q, {EW{1'b0}}, {FW{1'b0}}};
                end else if (s1_exp_q == {EW{1'b1}}) begin
                    res_d = {s1_sign_q, {EW{1'b1}}, {FW{1'b0}}};
                    of_d  = 1'b1;
                end else if (exp_ext > lz_ext) begin
                    res_d = {s1_sign_q, EW'(exp_diff), norm_frac};
                end else begin
`ifdef FP_PACK_SUBNORMAL_EN
                    res_d = {s1_sign_q, {EW{1'b0}}, sub_frac};
                    uf_d  = (sub_frac == '0);
`else
                    res_d = {s1_sign_q, {EW{1'b0}}, {FW{1'b0}}};
                    uf_d  = 1'b1;
`endif
                end
            end
        end
    end

    // Pipeline registers; reset discards both in-flight results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_exp_q   <= '0;
            s1_sig_q   <= '0;
            s1_sign_q  <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_lz_q    <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            nv_q       <= 1'b0;
            of_q       <= 1'b0;
            uf_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_exp_q   <= s1_exp_d;
            s1_sig_q   <= s1_sig_d;
            s1_sign_q  <= s1_sign_d;
            s1_inf_q   <= s1_inf_d;
            s1_nan_q   <= s1_nan_d;
            s1_zero_q  <= s1_zero_d;
            s1_lz_q    <= s1_lz_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            nv_q       <= nv_d;
            of_q       <= of_d;
            uf_q       <= uf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_pack
//  Description : Self-checking bench for fp_pack. A driver pushes expected
//                packed words into a scoreboard queue on every accept; an
//                independent monitor pops and compares on every output
//                transfer. Honours FP_PACK_SUBNORMAL_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_pack;

    localparam int FW = 23;
    localparam int EW = 8;

    typedef struct packed {
        logic [EW+FW:0] res;
        logic           nv;
        logic           of;
        logic           uf;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [EW-1:0]   exponent = '0;
    logic [FW:0]     significant = '0;
    logic            sign = 1'b0;
    logic            inf = 1'b0;
    logic            nan = 1'b0;
    logic            zero = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [EW+FW:0]  result;
    logic            flag_nv;
    logic            flag_of;
    logic            flag_uf;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    bit   bp_rand = 1'b0;
    bit   ready_force = 1'b1;

    fp_pack #(.FW(FW), .EW(EW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .exponent    (exponent),
        .significant (significant),
        .sign        (sign),
        .inf         (inf),
        .nan         (nan),
        .zero        (zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flag_nv     (flag_nv),
        .flag_of     (flag_of),
        .flag_uf     (flag_uf)
    );

    always #5 clk = ~clk;

    // Reference model: value-level normalisation by repeated doubling.
    function automatic exp_t model(input logic [EW-1:0] e, input logic [FW:0] m,
                                   input logic s, input logic fi, input logic fn,
                                   input logic fz);
        exp_t        r;
        int          ee;
        logic [FW:0] mm;
        longint      fr;
        int          emax;
        r  = '0;
        ee = int'(e);
        mm = m;
        fr = 0;
        emax = (1 << EW) - 1;
        if (fn) begin
            r.res = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
            r.nv  = 1'b1;
        end else if (fi) begin
            r.res = {s, {EW{1'b1}}, {FW{1'b0}}};
        end else if (fz || m == 0) begin
            r.res = {s, {(EW+FW){1'b0}}};
        end else if (ee == emax) begin
            r.res = {s, {EW{1'b1}}, {FW{1'b0}}};
            r.of  = 1'b1;
        end else begin
            while (!mm[FW]) begin
                mm = mm << 1;
                ee = ee - 1;
            end
            if (ee >= 1) begin
                r.res = {s, EW'(ee), mm[FW-1:0]};
            end else begin
`ifdef FP_PACK_SUBNORMAL_EN
                fr    = (longint'(m) << (((e == 0) ? 1 : int'(e)) - 1)) & ((64'd1 << FW) - 1);
                r.res = {s, {EW{1'b0}}, FW'(fr)};
                r.uf  = (fr == 0);
`else
                r.res = {s, {(EW+FW){1'b0}}};
                r.uf  = 1'b1;
`endif
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Drive one operand, push its expectation when accepted; returns just after the accepting edge.
    task automatic send(input logic [EW-1:0] e, input logic [FW:0] m, input logic s,
                        input logic fi, input logic fn, input logic fz,
                        input bit use_const, input exp_t cexp);
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_valid    = 1'b1;
        exponent    = e;
        significant = m;
        sign        = s;
        inf         = fi;
        nan         = fn;
        zero        = fz;
        for (int i = 0; i < 1000 && !done; i++) begin
            #1;
            if (in_ready) begin
                sb_q.push_back(use_const ? cexp : model(e, m, s, fi, fn, fz));
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stuck low, got 0 expected 1");
            in_valid = 1'b0;
        end
    endtask

    task automatic send_rand();
        logic [EW-1:0] e;
        logic [FW:0]   m;
        logic          s, fi, fn, fz;
        int            cat;
        cat = $urandom_range(0, 19);
        e   = EW'($urandom);
        m   = (FW+1)'($urandom) >> $urandom_range(0, FW + 1);
        s   = 1'($urandom);
        fi  = 1'b0;
        fn  = 1'b0;
        fz  = 1'b0;
        case (cat)
            0:       begin fn = 1'b1; fi = 1'($urandom); end
            1:       fi = 1'b1;
            2:       fz = 1'b1;
            3:       e  = '1;
            4:       m  = '0;
            5, 6, 7: e  = EW'($urandom_range(0, FW + 2));
            default: ;
        endcase
        send(e, m, s, fi, fn, fz, 1'b0, '0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
        chk(name, 64'(sb_q.size()), 64'd0);
    endtask

    // Back-pressure source for the consumer side.
    initial begin
        forever begin
            @(negedge clk);
            out_ready = bp_rand ? ($urandom_range(0, 2) != 0) : ready_force;
        end
    end

    // Monitor: compare every output transfer and check stability while stalled.
    initial begin
        bit   hold_pending;
        exp_t held;
        exp_t want;
        hold_pending = 1'b0;
        held         = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    checks++;
                    if (!out_valid || {result, flag_nv, flag_of, flag_uf} !== held) begin
                        errors++;
                        $display("FAIL hold: got v%b %h nv%b of%b uf%b expected v1 %h nv%b of%b uf%b",
                                 out_valid, result, flag_nv, flag_of, flag_uf,
                                 held.res, held.nv, held.of, held.uf);
                    end
                end
                hold_pending = out_valid && !out_ready;
                held         = {result, flag_nv, flag_of, flag_uf};
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got %h with empty scoreboard, expected no output", result);
                    end else begin
                        want = sb_q.pop_front();
                        if ({result, flag_nv, flag_of, flag_uf} !== want) begin
                            errors++;
                            $display("FAIL result: got %h nv%b of%b uf%b expected %h nv%b of%b uf%b",
                                     result, flag_nv, flag_of, flag_uf,
                                     want.res, want.nv, want.of, want.uf);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int   lat;
        exp_t c;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_flags", 64'({flag_nv, flag_of, flag_uf}), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors with known packed words; first one also measures latency.
        c = '{res: 32'h40000000, nv: 1'b0, of: 1'b0, uf: 1'b0};
        send(8'h80, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            lat++;
            if (out_valid) break;
        end
        chk("latency", 64'(lat), 64'd2);

        c = '{res: 32'hBF800000, nv: 1'b0, of: 1'b0, uf: 1'b0};
        send(8'h80, 24'h400000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c);
`ifdef FP_PACK_SUBNORMAL_EN
        c = '{res: 32'h00000002, nv: 1'b0, of: 1'b0, uf: 1'b0};
`else
        c = '{res: 32'h00000000, nv: 1'b0, of: 1'b0, uf: 1'b1};
`endif
        send(8'h02, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c);
        c = '{res: 32'h7FC00000, nv: 1'b1, of: 1'b0, uf: 1'b0};
        send(8'h13, 24'h5A5A5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, c);
        c = '{res: 32'hFF800000, nv: 1'b0, of: 1'b0, uf: 1'b0};
        send(8'h40, 24'h800000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, c);
        c = '{res: 32'h7F800000, nv: 1'b0, of: 1'b1, uf: 1'b0};
        send(8'hFF, 24'hC00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c);
        c = '{res: 32'h80000000, nv: 1'b0, of: 1'b0, uf: 1'b0};
        send(8'h55, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c);
        @(negedge clk);
        in_valid = 1'b0;
        drain("drain_directed");

        // Back-pressure: three back-to-back inputs with the consumer stalled.
        ready_force = 1'b0;
        repeat (2) @(negedge clk);
        send(8'h7F, 24'h800001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        send(8'h90, 24'h012345, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        fork
            send(8'h03, 24'h000F00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            begin
                repeat (4) @(posedge clk);
                ready_force = 1'b1;
            end
        join
        @(negedge clk);
        in_valid = 1'b0;
        drain("drain_bp");

        // Reset with both stages occupied.
        ready_force = 1'b0;
        repeat (2) @(negedge clk);
        send(8'h81, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        send(8'h82, 24'h100000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        ready_force = 1'b1;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_result", 64'(result), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        send(8'h80, 24'h400000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            lat++;
            if (out_valid) break;
        end
        chk("post_reset_latency", 64'(lat), 64'd2);
        drain("drain_reset");

        // Randomised traffic with random consumer stalls and input gaps.
        bp_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            send_rand();
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        bp_rand = 1'b0;
        drain("drain_random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
